// File: rtl/time_controller.sv
// Master RTIO timestamp generator: 64-bit time counter with a command port and
// an armed mode that starts counting a programmable delay after an external trigger edge.
module time_controller #(
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned DELAY_WIDTH   = 16
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_areset,
  input  logic                     cmd_valid_I,
  output logic                     cmd_ready_O,
  input  logic [2:0]               cmd_I,
  input  logic [COUNTER_WIDTH-1:0] cmd_data_I,
  input  logic                     trig_I,
  output logic [COUNTER_WIDTH-1:0] counter_O,
  output logic                     auto_start_O,
  output logic                     running_O,
  output logic                     armed_O,
  output logic                     overflow_O
);

  localparam logic [2:0] OpNop      = 3'd0;
  localparam logic [2:0] OpStart    = 3'd1;
  localparam logic [2:0] OpStop     = 3'd2;
  localparam logic [2:0] OpClear    = 3'd3;
  localparam logic [2:0] OpLoad     = 3'd4;
  localparam logic [2:0] OpArm      = 3'd5;
  localparam logic [2:0] OpDisarm   = 3'd6;
  localparam logic [2:0] OpSetDelay = 3'd7;

  typedef enum logic [1:0] {StStopped, StArmed, StDelay, StRunning} state_e;

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic                     overflow_q, overflow_d;
  logic                     auto_start_q, auto_start_d;
  logic [DELAY_WIDTH-1:0]   delay_reg_q, delay_reg_d;
  logic [DELAY_WIDTH-1:0]   delay_cnt_q, delay_cnt_d;
  logic                     sync1_q, sync2_q, prev_q;

  logic                     cmd_acc;
  logic                     trig_edge;
  logic                     halt_cmd;
  logic [COUNTER_WIDTH:0]   counter_inc;

  assign cmd_ready_O = ~s_axi_areset;
  assign cmd_acc     = cmd_valid_I & cmd_ready_O;
  assign trig_edge   = sync2_q & ~prev_q;
  assign halt_cmd    = cmd_acc & ((cmd_I == OpStop) | (cmd_I == OpDisarm));
  assign counter_inc = {1'b0, counter_q} + {{COUNTER_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q      <= StStopped;
      counter_q    <= '0;
      overflow_q   <= 1'b0;
      auto_start_q <= 1'b0;
      delay_reg_q  <= '0;
      delay_cnt_q  <= '0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      overflow_q   <= overflow_d;
      auto_start_q <= auto_start_d;
      delay_reg_q  <= delay_reg_d;
      delay_cnt_q  <= delay_cnt_d;
      sync1_q      <= trig_I;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    overflow_d   = overflow_q;
    auto_start_d = 1'b0;
    delay_reg_d  = delay_reg_q;
    delay_cnt_d  = delay_cnt_q;

    if (state_q == StRunning) begin
      counter_d = counter_inc[COUNTER_WIDTH-1:0];
      if (counter_inc[COUNTER_WIDTH]) overflow_d = 1'b1;
    end
    // Commands override the increment issued on the same edge.
    if (cmd_acc && cmd_I == OpClear) begin
      counter_d  = '0;
      overflow_d = 1'b0;
    end
    if (cmd_acc && cmd_I == OpLoad) counter_d = cmd_data_I;
    if (cmd_acc && cmd_I == OpSetDelay) delay_reg_d = cmd_data_I[DELAY_WIDTH-1:0];

    case (state_q)
      StStopped: begin
        if (cmd_acc && cmd_I == OpStart)    state_d = StRunning;
        else if (cmd_acc && cmd_I == OpArm) state_d = StArmed;
      end
      StArmed: begin
        if (cmd_acc && cmd_I == OpStart) state_d = StRunning;
        else if (halt_cmd)               state_d = StStopped;
        else if (trig_edge && !(cmd_acc && cmd_I != OpNop)) begin
          // Any real command in the same cycle swallows the edge.
          if (delay_reg_q == '0) begin
            state_d      = StRunning;
            auto_start_d = 1'b1;
          end else begin
            state_d     = StDelay;
            delay_cnt_d = delay_reg_q - {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      StDelay: begin
        if (halt_cmd) state_d = StStopped;
        else if (delay_cnt_q == '0) begin
          state_d      = StRunning;
          auto_start_d = 1'b1;
        end else begin
          delay_cnt_d = delay_cnt_q - {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      StRunning: begin
        if (cmd_acc && cmd_I == OpStop) state_d = StStopped;
      end
      default: state_d = StStopped;
    endcase
  end

  always_comb begin
    counter_O    = counter_q;
    overflow_O   = overflow_q;
    auto_start_O = auto_start_q;
    running_O    = (state_q == StRunning);
    armed_O      = (state_q == StArmed) || (state_q == StDelay);
  end

endmodule

// File: tb/tb_time_controller.sv
// Directed table-driven bench for time_controller, plus hand-written sequences for
// a delay reload mid-countdown and a reset that aborts a long DELAY.
module tb_time_controller;

  localparam logic [2:0] NOP = 3'd0, START = 3'd1, STOP = 3'd2, CLEAR = 3'd3;
  localparam logic [2:0] LOAD = 3'd4, ARM = 3'd5, DISARM = 3'd6, SETD = 3'd7;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [2:0]  cmd;
    logic [63:0] data;
    logic        trig;
    logic [63:0] exp_cnt;
    logic        exp_run;
    logic        exp_arm;
    logic        exp_auto;
    logic        exp_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [2:0]  cmd;
  logic [63:0] data;
  logic        trig;
  logic [63:0] counter;
  logic        auto_start;
  logic        running;
  logic        armed;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  time_controller #(.COUNTER_WIDTH(64), .DELAY_WIDTH(16)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .cmd_valid_I  (valid),
    .cmd_ready_O  (ready),
    .cmd_I        (cmd),
    .cmd_data_I   (data),
    .trig_I       (trig),
    .counter_O    (counter),
    .auto_start_O (auto_start),
    .running_O    (running),
    .armed_O      (armed),
    .overflow_O   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [2:0] c,
                              input logic [63:0] d, input logic t, input logic [63:0] ec,
                              input logic er, input logic ea, input logic eu, input logic eo);
    vec_t x;
    x.rst = r; x.valid = v; x.cmd = c; x.data = d; x.trig = t;
    x.exp_cnt = ec; x.exp_run = er; x.exp_arm = ea; x.exp_auto = eu; x.exp_ovf = eo;
    return x;
  endfunction

  // Drive one cycle at negedge, then check the registered outputs just after posedge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; valid = v.valid; cmd = v.cmd; data = v.data; trig = v.trig;
    #1 check({tag, " ready"}, 64'(ready), 64'(!v.rst));
    @(posedge clk);
    #1;
    check({tag, " counter"}, counter, v.exp_cnt);
    check({tag, " running"}, 64'(running), 64'(v.exp_run));
    check({tag, " armed"}, 64'(armed), 64'(v.exp_arm));
    check({tag, " auto_start"}, 64'(auto_start), 64'(v.exp_auto));
    check({tag, " overflow"}, 64'(overflow), 64'(v.exp_ovf));
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; cmd = NOP; data = '0; trig = 1'b0;

    // Reset, START, count to 10, STOP (the stop edge still increments).
    tbl.push_back(mk(1, 0, NOP,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, START, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, START, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 1; i <= 10; i++) tbl.push_back(mk(0, 0, NOP, 0, 0, 64'(i), 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, STOP,  0, 0, 11, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 11, 0, 0, 0, 0));
    // Wrap and sticky overflow, CLEAR while running.
    tbl.push_back(mk(0, 1, LOAD,  64'hFFFF_FFFF_FFFF_FFFE, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, START, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, CLEAR, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 1, 1, 0, 0, 0));
    // LOAD beats the same-edge increment.
    tbl.push_back(mk(0, 1, LOAD,  500, 0, 500, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 501, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, LOAD,  64'h1234, 0, 64'h1234, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 64'h1235, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, STOP,  0, 0, 64'h1236, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, CLEAR, 0, 0, 0, 0, 0, 0, 0));
    // START from ARMED: no strobe.
    tbl.push_back(mk(0, 1, ARM,   0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, START, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, STOP,  0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, CLEAR, 0, 0, 0, 0, 0, 0, 0));
    // Delay 3: trigger at k, DELAY from k+2, RUNNING + strobe after k+5.
    tbl.push_back(mk(0, 1, SETD,  3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, ARM,   0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 1, 0, 0, 1, 0, 0));
    for (int i = 1; i <= 4; i++) tbl.push_back(mk(0, 0, NOP, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, STOP,  0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, CLEAR, 0, 0, 0, 0, 0, 0, 0));
    // Delay 0: DISARM coincident with the edge wins.
    tbl.push_back(mk(0, 1, SETD,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, ARM,   0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, DISARM, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 0, 0, 0, 0, 0));
    // Delay 0: edge goes straight to RUNNING with strobe.
    tbl.push_back(mk(0, 1, ARM,   0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, STOP,  0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, CLEAR, 0, 0, 0, 0, 0, 0, 0));
    // A LOAD in ARMED discards a coincident edge; it is not queued.
    tbl.push_back(mk(0, 1, ARM,   0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, LOAD,  7, 0, 7, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 7, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, NOP,   0, 0, 7, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, DISARM, 0, 0, 7, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, CLEAR, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // SET_DELAY during a countdown leaves the countdown alone (delay 2: RUNNING after k+4).
    apply(mk(0, 1, SETD, 2, 0, 0, 0, 0, 0, 0), "seqA setd");
    apply(mk(0, 1, ARM,  0, 0, 0, 0, 1, 0, 0), "seqA arm");
    apply(mk(0, 0, NOP,  0, 1, 0, 0, 1, 0, 0), "seqA k");
    apply(mk(0, 0, NOP,  0, 0, 0, 0, 1, 0, 0), "seqA k+1");
    apply(mk(0, 0, NOP,  0, 0, 0, 0, 1, 0, 0), "seqA k+2");
    apply(mk(0, 1, SETD, 50, 0, 0, 0, 1, 0, 0), "seqA k+3");
    apply(mk(0, 0, NOP,  0, 0, 0, 1, 0, 1, 0), "seqA k+4");
    apply(mk(0, 1, STOP, 0, 0, 1, 0, 0, 0, 0), "seqA stop");

    // Reset at delay_cnt==50 of a 100-cycle countdown aborts without a strobe.
    apply(mk(0, 1, LOAD, 64'h55, 0, 64'h55, 0, 0, 0, 0), "seqB load");
    apply(mk(0, 1, SETD, 100, 0, 64'h55, 0, 0, 0, 0), "seqB setd");
    apply(mk(0, 1, ARM,  0, 0, 64'h55, 0, 1, 0, 0), "seqB arm");
    apply(mk(0, 0, NOP,  0, 1, 64'h55, 0, 1, 0, 0), "seqB k");
    apply(mk(0, 0, NOP,  0, 0, 64'h55, 0, 1, 0, 0), "seqB k+1");
    apply(mk(0, 0, NOP,  0, 0, 64'h55, 0, 1, 0, 0), "seqB k+2");
    for (int i = 0; i < 49; i++) apply(mk(0, 0, NOP, 0, 0, 64'h55, 0, 1, 0, 0), "seqB delay");
    apply(mk(1, 1, START, 0, 0, 0, 0, 0, 0, 0), "seqB reset");
    apply(mk(0, 0, NOP,  0, 0, 0, 0, 0, 0, 0), "seqB post");
    begin
      int pulses = 0;
      int busy = 0;
      for (int i = 0; i < 120; i++) begin
        @(posedge clk);
        #1;
        if (auto_start) pulses++;
        if (running || armed) busy++;
      end
      check("seqB auto_start pulses after reset", 64'(pulses), 64'd0);
      check("seqB running/armed cycles after reset", 64'(busy), 64'd0);
      check("seqB counter after idle", counter, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
